// File: rtl/yin_frame_scheduler_if.sv
// Bundle between the sample source, the difference engine and the pitch sink.
// The scheduler sits on the slave side; the environment drives the master side.
interface yin_frame_scheduler_if #(
    parameter int DATA_WIDTH              = 8,
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int WINDOW_SIZE_BITS        = 8,
    parameter int MAX_TAU                 = 40
);
    localparam int FRAME_LEN = 2**WINDOW_SIZE_BITS + MAX_TAU;
    localparam int TAU_W     = $clog2(MAX_TAU);
    localparam int IW        = INTERMEDIATE_DATA_WIDTH;

    logic                          sample_valid;
    logic [DATA_WIDTH-1:0]         sample_in;
    logic [IW-1:0]                 threshold;
    logic [FRAME_LEN*DATA_WIDTH-1:0] frame_data;
    logic                          engine_reset;
    logic                          engine_ready;
    logic [MAX_TAU*IW-1:0]         engine_results;
    logic                          pitch_valid;
    logic [TAU_W-1:0]              pitch_tau;
    logic                          voiced;
    logic [IW-1:0]                 pitch_value;
    logic                          busy;
    logic [7:0]                    overrun_count;

    modport master (
        output sample_valid, sample_in, threshold,
        output engine_ready, engine_results,
        input  frame_data, engine_reset,
        input  pitch_valid, pitch_tau, voiced, pitch_value,
        input  busy, overrun_count
    );

    modport slave (
        input  sample_valid, sample_in, threshold,
        input  engine_ready, engine_results,
        output frame_data, engine_reset,
        output pitch_valid, pitch_tau, voiced, pitch_value,
        output busy, overrun_count
    );
endinterface

// File: rtl/yin_frame_scheduler.sv
// Frames the sample stream, launches the difference engine every hop on a
// frozen snapshot and reports the absolute-threshold pitch estimate.
module yin_frame_scheduler #(
    parameter int DATA_WIDTH              = 8,
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int WINDOW_SIZE_BITS        = 8,
    parameter int MAX_TAU                 = 40,
    parameter int HOP_SIZE                = 64
) (
    input logic                  clk,
    input logic                  reset,
    yin_frame_scheduler_if.slave bus
);
    localparam int FRAME_LEN = 2**WINDOW_SIZE_BITS + MAX_TAU;
    localparam int FW        = FRAME_LEN * DATA_WIDTH;
    localparam int IW        = INTERMEDIATE_DATA_WIDTH;
    localparam int TW        = $clog2(MAX_TAU);
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam int HW        = $clog2(HOP_SIZE + 1);
    localparam logic [TW-1:0] LAST_TAU = TW'(MAX_TAU - 1);

    localparam logic [2:0] FILL   = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] BUSY   = 3'd2;
    localparam logic [2:0] SCAN   = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;

    logic [2:0]    state, state_n;
    logic [FW-1:0] shreg, shreg_n, frame_q;
    logic [CW-1:0] fill_cnt, fill_n;
    logic [HW-1:0] hop_cnt, hop_n;
    logic          hop_hit, launch, drop, in_flight, first_busy;
    logic [IW-1:0] thr, v;
    logic [TW-1:0] tau;
    logic [TW-1:0] best_tau, best_tau_n, min_tau, min_tau_n;
    logic [IW-1:0] best_val, best_val_n, min_val, min_val_n;
    logic          found, found_n, locked, locked_n;
    logic          pv_q, voiced_q;
    logic [TW-1:0] ptau_q;
    logic [IW-1:0] pval_q;
    logic [7:0]    ovr_q;

    always_comb begin
        shreg_n   = bus.sample_valid ?
                    {bus.sample_in, shreg[FW-1:DATA_WIDTH]} : shreg;
        fill_n    = (bus.sample_valid && fill_cnt != CW'(FRAME_LEN)) ?
                    fill_cnt + CW'(1) : fill_cnt;
        hop_hit   = hop_cnt == HW'(HOP_SIZE);
        // a sample arriving on the hop cycle belongs to the next hop
        hop_n     = hop_hit ? HW'(bus.sample_valid) :
                    hop_cnt + HW'(bus.sample_valid);
        in_flight = state == BUSY || state == SCAN || state == REPORT;
        drop      = hop_hit && in_flight;
        launch    = 1'b0;
        state_n   = state;
        unique case (state)
            FILL: begin
                hop_n = '0;
                if (fill_n == CW'(FRAME_LEN)) begin
                    launch  = 1'b1;
                    state_n = BUSY;
                end
            end
            IDLE: begin
                if (hop_hit) begin
                    launch  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY:    if (!first_busy && bus.engine_ready) state_n = SCAN;
            SCAN:    if (tau == LAST_TAU) state_n = REPORT;
            REPORT:  state_n = IDLE;
            default: state_n = FILL;
        endcase
    end

    always_comb begin
        v          = bus.engine_results[int'(tau)*IW +: IW];
        found_n    = found;
        locked_n   = locked;
        best_tau_n = best_tau;
        best_val_n = best_val;
        min_tau_n  = min_tau;
        min_val_n  = min_val;
        if (!found) begin
            if (v < thr) begin
                found_n    = 1'b1;
                best_tau_n = tau;
                best_val_n = v;
            end else if (v < min_val) begin
                min_tau_n = tau;
                min_val_n = v;
            end
        end else if (!locked) begin
            // follow a strictly descending run right after the crossing
            if (tau == best_tau + TW'(1) && v < best_val) begin
                best_tau_n = tau;
                best_val_n = v;
            end else begin
                locked_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            shreg      <= '0;
            frame_q    <= '0;
            fill_cnt   <= '0;
            hop_cnt    <= '0;
            first_busy <= 1'b0;
            thr        <= '0;
            tau        <= '0;
            found      <= 1'b0;
            locked     <= 1'b0;
            best_tau   <= '0;
            best_val   <= '0;
            min_tau    <= '0;
            min_val    <= '0;
            pv_q       <= 1'b0;
            voiced_q   <= 1'b0;
            ptau_q     <= '0;
            pval_q     <= '0;
            ovr_q      <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            fill_cnt   <= fill_n;
            hop_cnt    <= hop_n;
            first_busy <= launch;
            pv_q       <= 1'b0;
            if (launch) begin
                frame_q <= shreg_n;
                thr     <= bus.threshold;
            end
            if (drop && ovr_q != 8'hff) ovr_q <= ovr_q + 8'd1;
            if (state == BUSY) begin
                tau      <= TW'(1);
                found    <= 1'b0;
                locked   <= 1'b0;
                best_tau <= '0;
                best_val <= '0;
                min_tau  <= TW'(1);
                min_val  <= '1;
            end
            if (state == SCAN) begin
                found    <= found_n;
                locked   <= locked_n;
                best_tau <= best_tau_n;
                best_val <= best_val_n;
                min_tau  <= min_tau_n;
                min_val  <= min_val_n;
                if (tau != LAST_TAU) begin
                    tau <= tau + TW'(1);
                end else begin
                    pv_q     <= 1'b1;
                    voiced_q <= found_n;
                    ptau_q   <= found_n ? best_tau_n : min_tau_n;
                    pval_q   <= found_n ? best_val_n : min_val_n;
                end
            end
        end
    end

    assign bus.frame_data    = frame_q;
    assign bus.engine_reset  = !(state == BUSY || state == SCAN);
    assign bus.busy          = in_flight;
    assign bus.pitch_valid   = pv_q;
    assign bus.voiced        = voiced_q;
    assign bus.pitch_tau     = ptau_q;
    assign bus.pitch_value   = pval_q;
    assign bus.overrun_count = ovr_q;
endmodule
